// File: rtl/mips_muldiv_unit.sv
// MIPS EX-stage iterative multiply/divide unit owning the HI/LO registers.
// Latency: MTHI/MTLO and divide-by-zero in 1 cycle, MULT/DIV results XLEN cycles after issue.
// Backpressure: busy blocks new issue; start while busy is ignored; flush aborts in-flight work.
module mips_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;      // running product
  logic [2*XLEN-1:0] mcand;    // |a| shifted left one place per iteration
  logic [XLEN-1:0]   mplier;   // |b| shifted right one place per iteration
  logic [XLEN-1:0]   quo;      // dividend bits shift out as quotient bits shift in
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvs;
  logic              res_neg;  // product / quotient must be negated
  logic              rem_neg;  // remainder takes the sign of the dividend

  // Issue decode and operand magnitudes; op[0]=0 marks the signed variants.
  logic            issue, last, is_signed, a_neg, b_neg, is_mul, is_div;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    issue     = (state == IDLE) && start && !flush;
    last      = (cnt == CW'(XLEN - 1));
    is_mul    = (op[2:1] == 2'b00);
    is_div    = (op[2:1] == 2'b01);
    is_signed = !op[0];
    a_neg     = is_signed && a[XLEN-1];
    b_neg     = is_signed && b[XLEN-1];
    abs_a     = a_neg ? (~a + XLEN'(1)) : a;
    abs_b     = b_neg ? (~b + XLEN'(1)) : b;
  end

  // One shift-add step and one restoring-divide step, plus sign fix-up of the final values.
  logic [2*XLEN-1:0] acc_nxt, mul_res;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, q_res, r_res;

  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    mul_res = res_neg ? (~acc_nxt + (2*XLEN)'(1)) : acc_nxt;
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], !diff[XLEN]};
    q_res   = res_neg ? (~quo_nxt + XLEN'(1)) : quo_nxt;
    r_res   = rem_neg ? (~rem_nxt + XLEN'(1)) : rem_nxt;
  end

  // Next-state: issue from IDLE, leave MUL/DIV on the last iteration or on flush.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue && is_mul) state_nxt = MUL;
        else if (issue && is_div && (b != '0)) state_nxt = DIV;
      end
      MUL, DIV: begin
        if (flush || last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it drops with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Datapath: operand latch on issue, one iteration per edge, HI/LO writeback and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{XLEN{1'b0}}, abs_a};
            mplier  <= abs_b;
            quo     <= abs_a;
            rem     <= '0;
            dvs     <= abs_b;
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            if (op == 3'b100) hi <= a;
            if (op == 3'b101) lo <= a;
            if (is_div && (b == '0)) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end
          end
        end
        MUL: begin
          if (!flush) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
              {hi, lo} <= mul_res;
              done     <= 1'b1;
            end
          end
        end
        DIV: begin
          if (!flush) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
              hi   <= r_res;
              lo   <= q_res;
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed vector table, hand-written
// corner sequences (div-by-zero, flush, ignored start, async reset) and random ops
// compared against a 64-bit arithmetic reference model.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_hi, m_lo;   // reference HI/LO

  mips_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Drive one issue cycle starting at a negedge; returns at the negedge after the issue edge.
  task automatic issue1(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Issue a mult/div and wait (bounded) for done; lat counts edges after the issue edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl, output int lat,
                        output logic rdbz, output logic rbusy);
    issue1(o, x, y);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rh = hi; rl = lo; rdbz = div_by_zero; rbusy = busy;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic dbz);
    longint      sx, sy, sq, sr;
    logic [63:0] p, ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    dbz = 1'b0;
    case (o)
      3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = ux * uy; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin
        if (y == 0) dbz = 1'b1;
        else begin
          sq = sx / sy; sr = sx % sy;
          p = sq; m_lo = p[31:0];
          p = sr; m_hi = p[31:0];
        end
      end
      3'd3: begin
        if (y == 0) dbz = 1'b1;
        else begin
          p = ux / uy; m_lo = p[31:0];
          p = ux % uy; m_hi = p[31:0];
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    vec_t        tbl[8];
    logic [31:0] rh, rl;
    int          lat, ndone;
    logic        rdbz, rbusy, edbz, eb;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    tbl[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[6] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    tbl[7] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    // Reset state.
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    #12;
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_dbz", {63'b0, div_by_zero}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back-to-back on the edge right after done.
    for (int i = 0; i < 8; i++) begin
      op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_busy_early", i), {63'b0, busy}, 64'd1);
      lat = 0;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      chk($sformatf("vec%0d_hi", i), {32'b0, hi}, {32'b0, tbl[i].ehi});
      chk($sformatf("vec%0d_lo", i), {32'b0, lo}, {32'b0, tbl[i].elo});
      chk($sformatf("vec%0d_busy_at_done", i), {63'b0, busy}, 64'd0);
      chk($sformatf("vec%0d_dbz", i), {63'b0, div_by_zero}, 64'd0);
    end

    // MTHI/MTLO then DIVU by zero.
    issue1(3'd4, 32'h11, 32'h0);
    chk("mthi_hi", {32'b0, hi}, 64'h11);
    chk("mthi_busy", {63'b0, busy}, 64'd0);
    issue1(3'd5, 32'h22, 32'h0);
    chk("mtlo_lo", {32'b0, lo}, 64'h22);
    issue1(3'd3, 32'h55, 32'h0);
    chk("dbz_done", {63'b0, done}, 64'd1);
    chk("dbz_flag", {63'b0, div_by_zero}, 64'd1);
    chk("dbz_busy", {63'b0, busy}, 64'd0);
    chk("dbz_hi", {32'b0, hi}, 64'h11);
    chk("dbz_lo", {32'b0, lo}, 64'h22);
    @(negedge clk);
    chk("dbz_done_pulse", {63'b0, done}, 64'd0);

    // Flush while idle suppresses MTHI and the divide-by-zero pulse.
    flush = 1'b1;
    issue1(3'd4, 32'hDEAD, 32'h0);
    chk("flush_idle_mthi", {32'b0, hi}, 64'h11);
    issue1(3'd2, 32'h9, 32'h0);
    flush = 1'b0;
    chk("flush_idle_dbz", {62'b0, done, div_by_zero}, 64'd0);

    // MULTU, ignored second start at cycle 5, flush at cycle 10.
    issue1(3'd1, 32'h1234, 32'h5678);
    repeat (3) @(negedge clk);
    issue1(3'd4, 32'hBAD, 32'h0);
    repeat (4) @(negedge clk);
    chk("busy_before_flush", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hi", {32'b0, hi}, 64'h11);
    chk("flush_lo", {32'b0, lo}, 64'h22);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (done) ndone++; end
    chk("flush_no_done", 64'(ndone), 64'd0);
    chk("ignored_start_hi", {32'b0, hi}, 64'h11);

    run_op(3'd1, 32'd3, 32'd5, rh, rl, lat, rdbz, rbusy);
    chk("after_flush_lat", 64'(lat), 64'd32);
    chk("after_flush_res", {rh, rl}, 64'd15);
    m_hi = 32'd0; m_lo = 32'd15;

    // Random mult/div against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, edbz);
      run_op(rop, ra, rb, rh, rl, lat, rdbz, rbusy);
      chk($sformatf("rnd%0d_op%0d_lat", n, rop), 64'(lat), edbz ? 64'd0 : 64'd32);
      chk($sformatf("rnd%0d_op%0d_hilo", n, rop), {rh, rl}, {m_hi, m_lo});
      chk($sformatf("rnd%0d_op%0d_dbz", n, rop), {63'b0, rdbz}, {63'b0, edbz});
    end

    // MTHI then asynchronous reset in the middle of a MULT.
    issue1(3'd4, 32'h12345678, 32'h0);
    chk("mthi2_hi", {32'b0, hi}, 64'h12345678);
    eb = busy;
    chk("mthi2_busy", {63'b0, eb}, 64'd0);
    issue1(3'd0, 32'h7, 32'h9);
    repeat (9) @(negedge clk);
    chk("mid_mult_busy", {63'b0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hi", {32'b0, hi}, 64'd0);
    chk("async_rst_lo", {32'b0, lo}, 64'd0);
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", {63'b0, done | busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
